// File: rtl/playfield_writer.sv
// CPU write port into the 16x64 playfield tile RAM.
// Single writes queue in a small FIFO; a fill engine issues bulk writes.
module playfield_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CPU_WIDTH  = 12
) (
  input  logic                 i_Clk,
  input  logic                 reset,
  input  logic [CPU_WIDTH-1:0] cpu_addr,
  input  logic                 cpu_write,
  input  logic [CPU_WIDTH-1:0] cpu_wr_data,
  output logic [CPU_WIDTH-1:0] cpu_rd_data,
  input  logic                 vblank,
  output logic                 pf_write,
  output logic [9:0]           pf_write_addr,
  output logic [7:0]           pf_wr_data,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  logic [9:0]    addr_q;
  logic [7:0]    fill_value;
  logic          stride64;
  logic          vblank_only;
  logic          ovf;
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [9:0]    fill_addr;
  logic [10:0]   fill_cnt;

  logic          sel;
  logic [3:0]    reg_idx;
  logic          wr_ptr_reg;
  logic          wr_data_reg;
  logic          wr_fill_reg;
  logic          wr_fval_reg;
  logic          wr_ctrl_reg;
  logic [9:0]    step;
  logic          gate;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          bypass;
  logic          enq;
  logic [10:0]   fill_n;
  logic          fill_req;
  logic          fill_start;
  logic          start_issue;
  logic          fill_issue;
  logic          fill_done;
  logic          fill_active_nx;
  logic          issue;
  logic [CW-1:0] count_nx;
  logic [17:0]   head;
  logic [11:0]   status;
  logic          unused_bits;

  assign sel     = cpu_addr[11:10] == 2'h2;
  assign reg_idx = cpu_addr[3:0];

  assign wr_ptr_reg  = cpu_write && sel && reg_idx == 4'd0;
  assign wr_data_reg = cpu_write && sel && reg_idx == 4'd1;
  assign wr_fill_reg = cpu_write && sel && reg_idx == 4'd2;
  assign wr_fval_reg = cpu_write && sel && reg_idx == 4'd3;
  assign wr_ctrl_reg = cpu_write && sel && reg_idx == 4'd4;

  assign unused_bits = ^{cpu_addr[9:4], cpu_wr_data[CPU_WIDTH-1:11]};

  assign step       = stride64 ? 10'd64 : 10'd1;
  assign gate       = !vblank_only || vblank;
  assign fifo_empty = count == '0;
  assign fifo_full  = count == CW'(FIFO_DEPTH);
  assign head       = mem[rd_ptr];

  // An accepted write into an empty FIFO with the gate open skips the queue.
  assign pop     = gate && !fifo_empty;
  assign push_ok = wr_data_reg && (!fifo_full || pop);
  assign bypass  = push_ok && fifo_empty && gate;
  assign enq     = push_ok && !bypass;

  assign fill_n = (cpu_wr_data[10:0] > 11'd1024) ? 11'd1024
                                                 : cpu_wr_data[10:0];

  assign fill_req    = wr_fill_reg && fill_n != 11'd0;
  assign fill_start  = fill_req && state == S_IDLE;
  assign start_issue = fill_start && gate && fifo_empty;
  assign fill_issue  = state == S_FILL && gate && fifo_empty && !bypass;
  assign fill_done   = fill_issue && fill_cnt == 11'd1;

  assign fill_active_nx =
    (state == S_FILL && !fill_done) ||
    (fill_start && !(start_issue && fill_n == 11'd1));

  assign issue    = pop || bypass || fill_issue || start_issue;
  assign count_nx = count + CW'(enq) - CW'(pop);

  assign status = {4'b0, 2'b0, vblank_only, stride64,
                   1'b0, ovf, fifo_full, busy};

  always_comb begin
    cpu_rd_data = '0;
    if (sel) begin
      case (reg_idx)
        4'd0:    cpu_rd_data = CPU_WIDTH'(addr_q);
        4'd3:    cpu_rd_data = CPU_WIDTH'(fill_value);
        4'd4:    cpu_rd_data = CPU_WIDTH'(status);
        default: cpu_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (enq) begin
      mem[wr_ptr] <= {addr_q, cpu_wr_data[7:0]};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      pf_write      <= 1'b0;
      pf_write_addr <= '0;
      pf_wr_data    <= '0;
      busy          <= 1'b0;
      addr_q        <= '0;
      fill_value    <= '0;
      stride64      <= 1'b0;
      vblank_only   <= 1'b0;
      ovf           <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state         <= S_IDLE;
      fill_addr     <= '0;
      fill_cnt      <= '0;
    end else begin
      pf_write <= issue;
      if (pop) begin
        pf_write_addr <= head[17:8];
        pf_wr_data    <= head[7:0];
      end else if (bypass) begin
        pf_write_addr <= addr_q;
        pf_wr_data    <= cpu_wr_data[7:0];
      end else if (fill_issue) begin
        pf_write_addr <= fill_addr;
        pf_wr_data    <= fill_value;
      end else if (start_issue) begin
        pf_write_addr <= addr_q;
        pf_wr_data    <= fill_value;
      end

      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      busy  <= (count_nx != '0) || fill_active_nx || issue;

      if (wr_ptr_reg) begin
        addr_q <= cpu_wr_data[9:0];
      end else if (push_ok) begin
        addr_q <= addr_q + step;
      end

      if (wr_fval_reg) fill_value <= cpu_wr_data[7:0];

      if (wr_ctrl_reg) begin
        stride64    <= cpu_wr_data[0];
        vblank_only <= cpu_wr_data[1];
        if (cpu_wr_data[7]) ovf <= 1'b0;
      end
      if ((wr_data_reg && !push_ok) ||
          (fill_req && state == S_FILL)) begin
        ovf <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_issue) begin
            fill_addr <= addr_q + step;
            fill_cnt  <= fill_n - 11'd1;
            state     <= (fill_n == 11'd1) ? S_IDLE : S_FILL;
          end else if (fill_start) begin
            fill_addr <= addr_q;
            fill_cnt  <= fill_n;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_issue) begin
            fill_addr <= fill_addr + step;
            fill_cnt  <= fill_cnt - 11'd1;
            if (fill_done) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_writer.sv
// Directed bench for playfield_writer.
// Pulses are logged at the falling edge and compared to hand-built lists.
module tb_playfield_writer;

  localparam logic [11:0] R_ADDR = 12'h800;
  localparam logic [11:0] R_DATA = 12'h801;
  localparam logic [11:0] R_FCNT = 12'h802;
  localparam logic [11:0] R_FVAL = 12'h803;
  localparam logic [11:0] R_CTRL = 12'h804;

  logic        i_Clk = 1'b0;
  logic        reset;
  logic [11:0] cpu_addr;
  logic        cpu_write;
  logic [11:0] cpu_wr_data;
  logic [11:0] cpu_rd_data;
  logic        vblank;
  logic        pf_write;
  logic [9:0]  pf_write_addr;
  logic [7:0]  pf_wr_data;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int q_addr[$];
  int q_data[$];
  int q_cyc[$];

  playfield_writer #(.FIFO_DEPTH(4), .CPU_WIDTH(12)) dut (
    .i_Clk(i_Clk),
    .reset(reset),
    .cpu_addr(cpu_addr),
    .cpu_write(cpu_write),
    .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data),
    .vblank(vblank),
    .pf_write(pf_write),
    .pf_write_addr(pf_write_addr),
    .pf_wr_data(pf_wr_data),
    .busy(busy)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  always @(negedge i_Clk) begin
    if (pf_write === 1'b1) begin
      q_addr.push_back(int'(pf_write_addr));
      q_data.push_back(int'(pf_wr_data));
      q_cyc.push_back(cyc);
    end
  end

  task automatic clr_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [11:0] d);
    cpu_addr    = a;
    cpu_wr_data = d;
    cpu_write   = 1'b1;
    @(negedge i_Clk);
    cpu_write   = 1'b0;
    cpu_addr    = 12'h000;
    cpu_wr_data = 12'h000;
  endtask

  task automatic cpu_rd(input logic [11:0] a, output logic [11:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rd_data;
    cpu_addr = 12'h000;
  endtask

  task automatic test_reset();
    logic [11:0] rd;
    reset = 1'b1;
    idle(2);
    checks++;
    if (pf_write !== 1'b0) $display("FAIL rst_pf_write got %0h want 0", pf_write);
    else passes++;
    checks++;
    if (pf_write_addr !== 10'd0) $display("FAIL rst_pf_addr got %0h want 0", pf_write_addr);
    else passes++;
    checks++;
    if (pf_wr_data !== 8'd0) $display("FAIL rst_pf_data got %0h want 0", pf_wr_data);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %0h want 0", busy);
    else passes++;
    reset = 1'b0;
    idle(1);
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL rst_addr_reg got %0h want 0", rd);
    else passes++;
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL rst_status got %0h want 0", rd);
    else passes++;
    cpu_rd(R_FVAL, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL rst_fill_value got %0h want 0", rd);
    else passes++;
  endtask

  task automatic test_data_write();
    logic [11:0] rd;
    int w;
    cpu_wr(R_ADDR, 12'd5);
    clr_log();
    w = cyc;
    cpu_wr(R_DATA, 12'h021);
    checks++;
    if (pf_write !== 1'b1) $display("FAIL data_lat_pulse got %0h want 1", pf_write);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL data_busy got %0h want 1", busy);
    else passes++;
    idle(1);
    checks++;
    if (busy !== 1'b0) $display("FAIL data_busy_fall got %0h want 0", busy);
    else passes++;
    idle(2);
    checks++;
    if (q_addr.size() != 1) $display("FAIL data_count got %0d want 1", q_addr.size());
    else passes++;
    if (q_addr.size() == 1) begin
      checks++;
      if (q_addr[0] != 5 || q_data[0] != 'h21 || q_cyc[0] != w + 1)
        $display("FAIL data_pulse got a=%0d d=%0h c=%0d want a=5 d=21 c=%0d",
                 q_addr[0], q_data[0], q_cyc[0], w + 1);
      else passes++;
    end
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'd6) $display("FAIL data_addr_rb got %0d want 6", rd);
    else passes++;
    cpu_addr = 12'h005;
    #1;
    checks++;
    if (cpu_rd_data !== 12'h000) $display("FAIL unselected_rd got %0h want 0", cpu_rd_data);
    else passes++;
    cpu_rd(12'h805, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL unused_idx_rd got %0h want 0", rd);
    else passes++;
  endtask

  task automatic test_stride_wrap();
    logic [11:0] rd;
    cpu_wr(R_CTRL, 12'h001);
    cpu_wr(R_ADDR, 12'd1000);
    clr_log();
    cpu_wr(R_DATA, 12'h007);
    cpu_wr(R_DATA, 12'h007);
    idle(3);
    checks++;
    if (q_addr.size() != 2) $display("FAIL stride_count got %0d want 2", q_addr.size());
    else passes++;
    if (q_addr.size() == 2) begin
      checks++;
      if (q_addr[0] != 1000 || q_addr[1] != 40 || q_data[0] != 7 || q_data[1] != 7)
        $display("FAIL stride_addrs got %0d,%0d want 1000,40", q_addr[0], q_addr[1]);
      else passes++;
    end
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'd104) $display("FAIL stride_addr_rb got %0d want 104", rd);
    else passes++;
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h010) $display("FAIL stride_status got %0h want 010", rd);
    else passes++;
  endtask

  task automatic test_fill();
    logic [11:0] rd;
    cpu_wr(R_CTRL, 12'h000);
    cpu_wr(R_FVAL, 12'h03F);
    cpu_wr(R_ADDR, 12'd1020);
    clr_log();
    cpu_wr(R_FCNT, 12'd8);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (pf_write !== (i < 8))
        $display("FAIL fill_pulse_%0d got %0h want %0h", i, pf_write, (i < 8));
      else passes++;
      checks++;
      if (busy !== (i < 8))
        $display("FAIL fill_busy_%0d got %0h want %0h", i, busy, (i < 8));
      else passes++;
      if (i < 8) begin
        checks++;
        if (pf_write_addr !== 10'((1020 + i) % 1024) || pf_wr_data !== 8'h3F)
          $display("FAIL fill_word_%0d got a=%0d d=%0h want a=%0d d=3f",
                   i, pf_write_addr, pf_wr_data, (1020 + i) % 1024);
        else passes++;
      end
      idle(1);
    end
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'd1020) $display("FAIL fill_addr_rb got %0d want 1020", rd);
    else passes++;
  endtask

  task automatic test_overflow();
    logic [11:0] rd;
    cpu_wr(R_CTRL, 12'h002);
    vblank = 1'b0;
    cpu_wr(R_ADDR, 12'd100);
    clr_log();
    for (int i = 0; i < 5; i++) cpu_wr(R_DATA, 12'h0A0 + 12'(i));
    idle(3);
    checks++;
    if (q_addr.size() != 0) $display("FAIL ovf_gated got %0d pulses want 0", q_addr.size());
    else passes++;
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h027) $display("FAIL ovf_status_full got %0h want 027", rd);
    else passes++;
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'd104) $display("FAIL ovf_addr_rb got %0d want 104", rd);
    else passes++;
    vblank = 1'b1;
    idle(6);
    checks++;
    if (q_addr.size() != 4) $display("FAIL ovf_drain_count got %0d want 4", q_addr.size());
    else passes++;
    if (q_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_addr[i] != 100 + i || q_data[i] != 'hA0 + i)
          $display("FAIL ovf_order_%0d got a=%0d d=%0h want a=%0d d=%0h",
                   i, q_addr[i], q_data[i], 100 + i, 'hA0 + i);
        else passes++;
      end
    end
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h024) $display("FAIL ovf_status_drained got %0h want 024", rd);
    else passes++;
    cpu_wr(R_CTRL, 12'h082);
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h020) $display("FAIL ovf_clear got %0h want 020", rd);
    else passes++;
    cpu_wr(R_CTRL, 12'h000);
    vblank = 1'b0;
  endtask

  task automatic test_priority();
    logic [11:0] rd;
    int f;
    int ea[11];
    int ed[11];
    ea[0] = 200;
    ed[0] = 'h55;
    ea[1] = 200;
    ed[1] = 'h99;
    for (int i = 2; i < 11; i++) begin
      ea[i] = 199 + i;
      ed[i] = 'h55;
    end
    cpu_wr(R_FVAL, 12'h055);
    cpu_wr(R_ADDR, 12'd200);
    clr_log();
    f = cyc;
    cpu_wr(R_FCNT, 12'd10);
    cpu_wr(R_DATA, 12'h099);
    cpu_wr(R_FCNT, 12'd3);
    idle(15);
    checks++;
    if (q_addr.size() != 11) $display("FAIL prio_count got %0d want 11", q_addr.size());
    else passes++;
    if (q_addr.size() == 11) begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (q_addr[i] != ea[i] || q_data[i] != ed[i] || q_cyc[i] != f + 1 + i)
          $display("FAIL prio_%0d got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d",
                   i, q_addr[i], q_data[i], q_cyc[i], ea[i], ed[i], f + 1 + i);
        else passes++;
      end
    end
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h004) $display("FAIL prio_ovf got %0h want 004", rd);
    else passes++;
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'd201) $display("FAIL prio_addr_rb got %0d want 201", rd);
    else passes++;
    cpu_wr(R_CTRL, 12'h080);
  endtask

  task automatic test_clamp();
    logic [11:0] rd;
    cpu_wr(R_FVAL, 12'h011);
    cpu_wr(R_ADDR, 12'd0);
    clr_log();
    cpu_wr(R_FCNT, 12'd0);
    idle(3);
    checks++;
    if (q_addr.size() != 0 || busy !== 1'b0)
      $display("FAIL zero_fill got %0d pulses busy=%0h want 0 0", q_addr.size(), busy);
    else passes++;
    cpu_wr(R_FCNT, 12'hFFF);
    idle(1030);
    checks++;
    if (q_addr.size() != 1024) $display("FAIL clamp_count got %0d want 1024", q_addr.size());
    else passes++;
    if (q_addr.size() == 1024) begin
      checks++;
      if (q_addr[0] != 0 || q_addr[1023] != 1023 || q_data[1023] != 'h11)
        $display("FAIL clamp_ends got %0d,%0d want 0,1023", q_addr[0], q_addr[1023]);
      else passes++;
    end
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL clamp_status got %0h want 000", rd);
    else passes++;
  endtask

  task automatic test_reset_mid_fill();
    logic [11:0] rd;
    cpu_wr(R_FVAL, 12'h012);
    cpu_wr(R_ADDR, 12'd300);
    cpu_wr(R_FCNT, 12'd20);
    idle(3);
    reset = 1'b1;
    idle(1);
    checks++;
    if (pf_write !== 1'b0) $display("FAIL rmid_pf_write got %0h want 0", pf_write);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL rmid_busy got %0h want 0", busy);
    else passes++;
    reset = 1'b0;
    clr_log();
    idle(4);
    checks++;
    if (q_addr.size() != 0) $display("FAIL rmid_no_resume got %0d pulses want 0", q_addr.size());
    else passes++;
    cpu_rd(R_ADDR, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL rmid_addr got %0h want 0", rd);
    else passes++;
    cpu_rd(R_FVAL, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL rmid_fval got %0h want 0", rd);
    else passes++;
    cpu_rd(R_CTRL, rd);
    checks++;
    if (rd !== 12'h000) $display("FAIL rmid_status got %0h want 0", rd);
    else passes++;
  endtask

  initial begin
    reset       = 1'b1;
    cpu_addr    = 12'h000;
    cpu_write   = 1'b0;
    cpu_wr_data = 12'h000;
    vblank      = 1'b0;
    idle(1);
    test_reset();
    test_data_write();
    test_stride_wrap();
    test_fill();
    test_overflow();
    test_priority();
    test_clamp();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
